ahblite_seg7_disp: RTL

AHB-Lite slave that drives the board's four-digit multiplexed seven-segment display from memory-mapped registers. It sits on the AHBLITE_SYS bus decoder as a peripheral and produces the top-level `seg`, `dp` and `an` pins. Software writes four hex nibbles plus decimal-point bits, and the block time-multiplexes them onto the shared segment lines.

---
 rtl/ahblite_seg7_disp_if.sv | 24 ++
 rtl/ahblite_seg7_disp.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ahblite_seg7_disp_if.sv
// AHB-Lite bus bundle for the seven-segment display peripheral.
// The master modport drives the transfer and the slave modport answers it.
interface ahblite_seg7_disp_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahblite_seg7_disp.sv
// AHB-Lite slave that multiplexes four hex digits onto a shared seven-segment bus.
// Optional leading-zero blanking is compiled in with `define SEG7_BLANKLZ_EN.
module ahblite_seg7_disp #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                CLK,
    input  logic                RESET,
    ahblite_seg7_disp_if.slave  bus,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [3:0]          an
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic          wr_q;
    logic [1:0]    addr_q;
    logic [15:0]   digits;
    logic [3:0]    dpr;
    logic          enable;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          sel;
    logic          blank;
    logic [3:0]    nib;
    logic [31:0]   rdata;

    assign sel           = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign bus.HRDATA    = rdata;

`ifdef SEG7_BLANKLZ_EN
    logic       blanklz;
    logic [3:0] lz;
    logic       unused_bus;

    // lz[n]: nibbles n..3 are all zero; digit 0 is never blanked.
    always_comb begin
        lz[3] = (digits[15:12] == 4'h0);
        lz[2] = lz[3] & (digits[11:8] == 4'h0);
        lz[1] = lz[2] & (digits[7:4] == 4'h0);
        lz[0] = 1'b0;
    end
    assign blank      = blanklz & lz[idx];
    assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0],
                          bus.HWDATA[31:16]};
`else
    logic unused_bus;
    assign blank      = 1'b0;
    assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0],
                          bus.HWDATA[31:16], bus.HWDATA[1]};
`endif

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Bus pipeline: address phase captured here, write lands one cycle later.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_q    <= 1'b0;
            addr_q  <= 2'd0;
            digits  <= 16'h0;
            dpr     <= 4'h0;
            enable  <= 1'b1;
`ifdef SEG7_BLANKLZ_EN
            blanklz <= 1'b0;
`endif
        end else begin
            wr_q <= sel & bus.HWRITE;
            if (sel)
                addr_q <= bus.HADDR[3:2];
            if (wr_q) begin
                case (addr_q)
                    2'd0: digits <= bus.HWDATA[15:0];
                    2'd1: dpr    <= bus.HWDATA[3:0];
                    2'd2: begin
                        enable  <= bus.HWDATA[0];
`ifdef SEG7_BLANKLZ_EN
                        blanklz <= bus.HWDATA[1];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr_q)
            2'd0: rdata[15:0] = digits;
            2'd1: rdata[3:0]  = dpr;
            2'd2: begin
                rdata[0] = enable;
`ifdef SEG7_BLANKLZ_EN
                rdata[1] = blanklz;
`endif
            end
            default: ;
        endcase
    end

    // Scan timer keeps running while disabled so re-enabling stays in phase.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign nib = digits[{idx, 2'b00} +: 4];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= 4'hF;
        end else begin
            an  <= enable ? ~(4'b0001 << idx) : 4'hF;
            seg <= (enable && !blank) ? hex7(nib) : 7'h7F;
            dp  <= enable ? ~dpr[idx] : 1'b1;
        end
    end
endmodule
